// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM port arbiter:
// FSM state encoding, ram_op size codes (shared with the decoder),
// the misalignment predicate and byte-lane helpers.
package mem_port_arbiter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_IF_RSP,
    ST_D_RD,
    ST_D_RSP,
    ST_D_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_ERR
  } arb_state_t;

  // Access size codes, identical to the decoder's ram_op field.
  localparam logic [1:0] RAM_B = 2'b01;
  localparam logic [1:0] RAM_H = 2'b10;
  localparam logic [1:0] RAM_W = 2'b11;

  // Byte-lane masks (bit i covers data bits [8*i+7:8*i]).
  localparam logic [3:0] LANES_NONE    = 4'b0000;
  localparam logic [3:0] LANE_B0       = 4'b0001;
  localparam logic [3:0] LANES_LO_HALF = 4'b0011;
  localparam logic [3:0] LANES_HI_HALF = 4'b1100;
  localparam logic [3:0] LANES_ALL     = 4'b1111;

  // Size code 00 behaves as a full word.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    return (op == 2'b00) ? RAM_W : op;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] addr_lo);
    case (norm_op(op))
      RAM_H:   return addr_lo[0];
      RAM_W:   return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Lanes touched by a store of the given size at the given byte offset.
  function automatic logic [3:0] sel_lanes(input logic [1:0] op, input logic [1:0] addr_lo);
    case (norm_op(op))
      RAM_B:   return LANE_B0 << addr_lo;
      RAM_H:   return addr_lo[1] ? LANES_HI_HALF : LANES_LO_HALF;
      default: return LANES_ALL;
    endcase
  endfunction

  // Copy right-aligned store data into every lane it could land in.
  function automatic logic [31:0] lane_replicate(input logic [1:0] op, input logic [31:0] wdata);
    case (norm_op(op))
      RAM_B:   return {4{wdata[7:0]}};
      RAM_H:   return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_store_lane_merge.sv
// Combinational byte-lane merge for sub-word stores: replaces the
// lanes selected by size/offset in the old RAM word with store data,
// and reports the lane mask used.
module store_lane_merge
  import mem_port_arbiter_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged,
  output logic [3:0]  lanes
);

  logic [31:0] rep_data;

  // Per-lane select between the replicated store data and the old word.
  always_comb begin
    rep_data = lane_replicate(op, wdata);
    lanes    = sel_lanes(op, addr_lo);
    merged   = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) merged[8*i +: 8] = rep_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous-read RAM between instruction
// fetch and load/store. Data requests win over fetch; sub-word stores
// are done as read-modify-write, misaligned data accesses are rejected.
// Optional build macro MEM_BYTE_EN: adds mem_be and performs sub-word
// stores as single byte-enabled writes instead of read-modify-write.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_AW         = 14,
  parameter int RESET_IDLE_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_op,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_misalign,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MEM_BYTE_EN
  ,
  output logic [3:0]        mem_be
`endif
);

  localparam int CNT_W = (RESET_IDLE_CYC > 0) ? $clog2(RESET_IDLE_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(RESET_IDLE_CYC);

  arb_state_t          state_q;
  logic [1:0]          op_q;
  logic [MEM_AW+1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [CNT_W-1:0]    hold_q;

  logic [31:0]         merged_word;
  logic [3:0]          merged_lanes;

  store_lane_merge u_merge (
    .old_word (mem_rdata),
    .wdata    (wdata_q),
    .op       (op_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged_word),
    .lanes    (merged_lanes)
  );

  // Address bits above the RAM size wrap; merge outputs not needed in
  // this build are tied off here.
  logic unused_bits;
`ifdef MEM_BYTE_EN
  assign unused_bits = &{1'b0, if_addr[31:MEM_AW+2], d_addr[31:MEM_AW+2], merged_word};
`else
  assign unused_bits = &{1'b0, if_addr[31:MEM_AW+2], d_addr[31:MEM_AW+2], merged_lanes};
`endif

  // Access sequencer: grants in IDLE, latches the operation, then walks
  // the read/response/write states back to IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= HOLD_INIT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hold_q != '0) begin
            hold_q <= hold_q - 1'b1;
          end else if (d_req) begin
            op_q    <= norm_op(d_op);
            addr_q  <= d_addr[MEM_AW+1:0];
            wdata_q <= d_wdata;
            if (is_misaligned(d_op, d_addr[1:0])) begin
              state_q <= ST_ERR;
            end else if (!d_we) begin
              state_q <= ST_D_RD;
`ifdef MEM_BYTE_EN
            end else begin
              state_q <= ST_D_WR;
            end
`else
            end else if (norm_op(d_op) == RAM_W) begin
              state_q <= ST_D_WR;
            end else begin
              state_q <= ST_RMW_RD;
            end
`endif
          end else if (if_req) begin
            addr_q  <= if_addr[MEM_AW+1:0];
            state_q <= ST_IF_RD;
          end
        end
        ST_IF_RD:  state_q <= ST_IF_RSP;
        ST_D_RD:   state_q <= ST_D_RSP;
`ifndef MEM_BYTE_EN
        ST_RMW_RD: state_q <= ST_RMW_WR;
`endif
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Output decode from state and latched operation; reset masks every
  // strobe so an interrupted write never reaches the RAM.
  always_comb begin
    if_ack     = 1'b0;
    d_ack      = 1'b0;
    d_misalign = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
`ifdef MEM_BYTE_EN
    mem_be     = LANES_NONE;
`endif
    case (state_q)
      ST_IF_RD, ST_D_RD: mem_en = 1'b1;
      ST_IF_RSP:         if_ack = 1'b1;
      ST_D_RSP:          d_ack  = 1'b1;
      ST_D_WR: begin
        mem_en = 1'b1;
        mem_we = 1'b1;
        d_ack  = 1'b1;
`ifdef MEM_BYTE_EN
        mem_wdata = lane_replicate(op_q, wdata_q);
        mem_be    = merged_lanes;
`else
        mem_wdata = wdata_q;
`endif
      end
`ifndef MEM_BYTE_EN
      ST_RMW_RD: mem_en = 1'b1;
      ST_RMW_WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        d_ack     = 1'b1;
        mem_wdata = merged_word;
      end
`endif
      ST_ERR: begin
        d_ack      = 1'b1;
        d_misalign = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      if_ack     = 1'b0;
      d_ack      = 1'b0;
      d_misalign = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
`ifdef MEM_BYTE_EN
      mem_be     = LANES_NONE;
`endif
    end
  end

  assign mem_addr = addr_q[MEM_AW+1:2];
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read data/instruction RAM between the instruction-fetch path and the load/store path of the miniLA core.
- Arbitrates between the two requesters and sequences each access through a small FSM.
- Performs sub-word stores (ST.B/ST.H) as read-modify-write and flags misaligned accesses.
- Sits between the core (fetch unit plus ram_we/ram_op from the decoder) and the RAM macro.

Parameters:
- MEM_AW, 14: RAM word-address width. mem_addr = addr[MEM_AW+1:2].
- RESET_IDLE_CYC, 0: extra cycles held in IDLE after reset deasserts before the first grant (0 = none).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high; has priority over every other input.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch byte address; bits [1:0] are ignored.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  32  fetched word (mem_rdata passed through).
- d_req  in  1  data request; held high with stable operands until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_op  in  2  access size: RAM_B=01, RAM_H=10, RAM_W=11 (same encoding as ram_op); 00 is treated as W.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  32  full aligned word, valid with d_ack on loads; byte/half extraction is done downstream.
- d_misalign  out  1  pulses with d_ack when the access was rejected.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  MEM_AW  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data, valid one cycle after a read-enable cycle.

Behaviour:
- States: IDLE, IF_RD, IF_RSP, D_RD, D_RSP, D_WR, RMW_RD, RMW_WR, ERR.
- The operation is latched into internal registers when leaving IDLE. All outputs decode combinationally from the state and those registers.
- IDLE selection, in priority order:
  - d_req with a misaligned address (H with addr[0]=1, or W with addr[1:0]≠0) → ERR.
  - d_req load → D_RD.
  - d_req store W → D_WR.
  - d_req store B/H → RMW_RD.
  - Otherwise if_req → IF_RD.
  - Otherwise stay in IDLE.
- Data always wins over fetch. A fetch that loses stays pending and is granted in the IDLE cycle after d_ack.
- Per-state actions:
  - IF_RD / D_RD / RMW_RD: mem_en=1, mem_we=0.
  - IF_RSP: if_ack=1, then → IDLE.
  - D_RSP: d_ack=1, then → IDLE.
  - D_WR: mem_en=mem_we=1, mem_wdata=d_wdata, d_ack=1, then → IDLE.
  - RMW_WR: mem_en=mem_we=1; mem_wdata = mem_rdata with the selected lanes replaced (B: lane addr[1:0]; H: lanes {addr[1],0} and {addr[1],1}); d_ack=1, then → IDLE.
  - ERR: d_ack=1, d_misalign=1, no RAM access, then → IDLE.
- Latency, with the request seen in IDLE at cycle 0:
  - Store W: ack in cycle 1.
  - Load, fetch, store B/H: ack in cycle 2.
  - Misaligned: ack in cycle 1.
- After every ack the FSM spends one IDLE cycle. A req still high in that cycle is treated as a new request, so requesters must drop or replace req in the cycle after ack.
- Exactly one ack pulse per request. if_ack and d_ack are never high in the same cycle.
- Reset:
  - While rst=1: mem_en, mem_we, if_ack, d_ack and d_misalign are forced to 0, including mid-operation, so no write is issued during the reset cycle.
  - Next state is IDLE; latched registers clear to 0. Any in-flight access is dropped with no ack.
  - After reset, if RESET_IDLE_CYC>0, the FSM holds IDLE for that many cycles before granting.
- Reset values of all other outputs: if_rdata/d_rdata follow mem_rdata (don't-care); mem_addr=0; mem_wdata=0.
- Address arithmetic: word index = addr[MEM_AW+1:2]. Upper bits are ignored, so addresses wrap modulo the RAM size.

Optional Feature:
- MEM_BYTE_EN (macro MEM_BYTE_EN).
- Defined:
  - Adds output mem_be[3:0].
  - Stores B/H use D_WR with d_wdata replicated to all lanes and mem_be selecting the lanes; all stores ack in cycle 1.
  - RMW_RD and RMW_WR are not compiled in.
  - mem_be=4'b1111 on W stores and 0 when not writing.
- Undefined: read-modify-write as specified above; no mem_be port.

Decomposition:
- Shared package holds:
  - the state enum;
  - RAM_B/RAM_H/RAM_W encodings (shared with the decoder's ram_op);
  - the misalignment predicate;
  - lane-mask constants.
- One sub-module, store_lane_merge (combinational): inputs old word, d_wdata, d_op, addr[1:0]; outputs merged word and 4-bit lane mask. It is used by RMW_WR, and for mem_be under MEM_BYTE_EN.

Test Plan:
- if_req, if_addr=0x0000_0010, RAM word 4=0x1234_5678 → mem_addr=4 read in cycle 1; if_ack with if_rdata=0x1234_5678 in cycle 2.
- d_req store W, addr 0x20, wdata 0xDEAD_BEEF → cycle 1 has mem_we=1, mem_addr=8, d_ack=1; a subsequent load of 0x20 returns 0xDEAD_BEEF.
- Word 8=0x1122_3344, then store B to 0x22 with wdata 0xAB → read then write of 0x11AB_3344, d_ack in cycle 2. Store H to 0x22 with wdata 0xCAFE → 0xCAFE_3344.
- if_req and d_req (load) high together → d_ack in cycle 2, IDLE in cycle 3, if_ack in cycle 5, never both acks in one cycle.
- Store H to 0x21 → cycle 1 has d_ack=d_misalign=1, mem_en=0, and the RAM is unchanged. Store W to 0x22 → same response.
- rst asserted during RMW_WR → mem_we=0 that cycle, the RAM word is unchanged, no d_ack, IDLE next.
